// File: rtl/jtframe_dump_trigger.sv
// rtl/jtframe_dump_trigger.sv - frame counter and windowed dump-enable from VS.
// Define JTFRAME_DUMP_LOADROM_EN to hold counting until ROM download completes.
module jtframe_dump_trigger #(
  parameter int unsigned START_FRAME    = 0,
  parameter int unsigned DUMP_LEN       = 0,
  parameter bit          VS_ACTIVE_HIGH = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vs,
  input  logic        downloading,
  output logic [31:0] frame_cnt,
  output logic        frame_pulse,
  output logic        dump_en,
  output logic        dump_start,
  output logic        dump_stop,
  output logic [31:0] dump_frames
);

  localparam logic        ACT      = VS_ACTIVE_HIGH;
  localparam logic [31:0] START    = START_FRAME;
  localparam logic [31:0] LEN_LAST = DUMP_LEN - 1;
  localparam bit          LIMITED  = (DUMP_LEN != 0);

  typedef enum logic [1:0] {WAIT_DL, COUNT, DUMP, DONE} state_t;

  state_t state;
  logic   vs_last;
  logic   boundary;

  assign boundary = (vs_last == ACT) && (vs != ACT);

`ifdef JTFRAME_DUMP_LOADROM_EN
  logic dl_last;
  logic dl_rise;
  logic dl_fall;

  assign dl_rise = !dl_last && downloading;
  assign dl_fall = dl_last && !downloading;
`else
  logic unused_downloading;

  assign unused_downloading = downloading;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_last     <= ~ACT;
      frame_pulse <= 1'b0;
      frame_cnt   <= '0;
      dump_frames <= '0;
      dump_en     <= 1'b0;
      dump_start  <= 1'b0;
      dump_stop   <= 1'b0;
`ifdef JTFRAME_DUMP_LOADROM_EN
      dl_last     <= 1'b0;
      state       <= WAIT_DL;
`else
      state       <= COUNT;
`endif
    end else begin
      vs_last     <= vs;
      frame_pulse <= boundary;
      dump_start  <= 1'b0;
      dump_stop   <= 1'b0;
`ifdef JTFRAME_DUMP_LOADROM_EN
      dl_last     <= downloading;
      // A new download abandons any window silently; no stop strobe.
      if (dl_rise) begin
        state       <= WAIT_DL;
        frame_cnt   <= '0;
        dump_frames <= '0;
        dump_en     <= 1'b0;
      end else
`endif
      begin
        case (state)
          WAIT_DL: begin
            frame_cnt <= '0;
            dump_en   <= 1'b0;
`ifdef JTFRAME_DUMP_LOADROM_EN
            if (dl_fall) state <= COUNT;
`endif
          end
          COUNT: begin
            if (frame_pulse) begin
              frame_cnt <= frame_cnt + 32'd1;
              if (frame_cnt == START) begin
                state       <= DUMP;
                dump_en     <= 1'b1;
                dump_start  <= 1'b1;
                dump_frames <= '0;
              end
            end
          end
          DUMP: begin
            if (frame_pulse) begin
              frame_cnt <= frame_cnt + 32'd1;
              if (dump_frames != '1) dump_frames <= dump_frames + 32'd1;
              if (LIMITED && dump_frames == LEN_LAST) begin
                state     <= DONE;
                dump_en   <= 1'b0;
                dump_stop <= 1'b1;
              end
            end
          end
          DONE: begin
            if (frame_pulse) frame_cnt <= frame_cnt + 32'd1;
          end
          default: state <= COUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtframe_dump_trigger.sv
// tb/tb_jtframe_dump_trigger.sv - scoreboard bench for jtframe_dump_trigger.
// Four instances share vs; expectations are queued per instance at each driven VS edge.
module tb_jtframe_dump_trigger;

  localparam int SF  [4] = '{3, 0, 3, 1};
  localparam int LEN [4] = '{2, 0, 2, 1};
  localparam bit ACT [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, vs, downloading;
  logic [31:0] fc [4];
  logic [31:0] df [4];
  logic        fp [4];
  logic        en [4];
  logic        st [4];
  logic        sp [4];

  jtframe_dump_trigger #(.START_FRAME(SF[0]), .DUMP_LEN(LEN[0]), .VS_ACTIVE_HIGH(ACT[0])) u0 (
    .clk(clk), .rst_n(rst_n), .vs(vs), .downloading(downloading), .frame_cnt(fc[0]),
    .frame_pulse(fp[0]), .dump_en(en[0]), .dump_start(st[0]), .dump_stop(sp[0]), .dump_frames(df[0]));
  jtframe_dump_trigger #(.START_FRAME(SF[1]), .DUMP_LEN(LEN[1]), .VS_ACTIVE_HIGH(ACT[1])) u1 (
    .clk(clk), .rst_n(rst_n), .vs(vs), .downloading(downloading), .frame_cnt(fc[1]),
    .frame_pulse(fp[1]), .dump_en(en[1]), .dump_start(st[1]), .dump_stop(sp[1]), .dump_frames(df[1]));
  jtframe_dump_trigger #(.START_FRAME(SF[2]), .DUMP_LEN(LEN[2]), .VS_ACTIVE_HIGH(ACT[2])) u2 (
    .clk(clk), .rst_n(rst_n), .vs(vs), .downloading(downloading), .frame_cnt(fc[2]),
    .frame_pulse(fp[2]), .dump_en(en[2]), .dump_start(st[2]), .dump_stop(sp[2]), .dump_frames(df[2]));
  jtframe_dump_trigger #(.START_FRAME(SF[3]), .DUMP_LEN(LEN[3]), .VS_ACTIVE_HIGH(ACT[3])) u3 (
    .clk(clk), .rst_n(rst_n), .vs(vs), .downloading(downloading), .frame_cnt(fc[3]),
    .frame_pulse(fp[3]), .dump_en(en[3]), .dump_start(st[3]), .dump_stop(sp[3]), .dump_frames(df[3]));

  typedef struct {
    int          cyc;
    logic [31:0] fc;
    logic [31:0] df;
    logic        en;
    logic        st;
    logic        sp;
  } exp_t;

  exp_t        q [4][$];
  exp_t        cur [4];
  bit          pend [4];
  int          n [4];
  logic [31:0] exp_fc [4];
  bit          in_dl;
  bit          mon_on = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Closed-form window: pulse number nn (1-based since counting began).
  function automatic exp_t model(input int i, input int nn, input logic [31:0] f, input int c);
    exp_t e;
    int   d;
    e.cyc = c; e.fc = f; e.df = '0; e.en = 1'b0; e.st = 1'b0; e.sp = 1'b0;
    if (nn >= SF[i] + 1) begin
      d    = nn - SF[i] - 1;
      e.en = (LEN[i] == 0) || (d < LEN[i]);
      e.st = (d == 0);
      e.sp = (LEN[i] != 0) && (d == LEN[i]);
      e.df = (LEN[i] != 0 && d > LEN[i]) ? 32'(LEN[i]) : 32'(d);
    end
    return e;
  endfunction

  task automatic push(input int i);
    if (in_dl) begin
      q[i].push_back(model(i, 0, 32'd0, cyc + 1));
    end else begin
      n[i]++;
      exp_fc[i] = exp_fc[i] + 32'd1;
      q[i].push_back(model(i, n[i], exp_fc[i], cyc + 1));
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      n[i]      = 0;
      exp_fc[i] = '0;
    end
`ifdef JTFRAME_DUMP_LOADROM_EN
    in_dl = 1'b1;
`else
    in_dl = 1'b0;
`endif
  endtask

  task automatic frame();
    @(negedge clk);
    vs = 1'b1;
    for (int i = 0; i < 4; i++) if (!ACT[i]) push(i);
    repeat (10) @(negedge clk);
    vs = 1'b0;
    for (int i = 0; i < 4; i++) if (ACT[i]) push(i);
    repeat (89) @(negedge clk);
  endtask

  task automatic post_reset();
`ifdef JTFRAME_DUMP_LOADROM_EN
    downloading = 1'b1;
    repeat (3) frame();
    chk("u0_fc_during_download", fc[0], 32'd0);
    @(negedge clk);
    downloading = 1'b0;
    in_dl = 1'b0;
    repeat (3) @(negedge clk);
`endif
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      for (int i = 0; i < 4; i++) begin
        if (pend[i]) begin
          pend[i] = 1'b0;
          chk($sformatf("u%0d_frame_cnt", i), fc[i], cur[i].fc);
          chk($sformatf("u%0d_dump_frames", i), df[i], cur[i].df);
          chk($sformatf("u%0d_dump_en", i), {31'd0, en[i]}, {31'd0, cur[i].en});
          chk($sformatf("u%0d_dump_start", i), {31'd0, st[i]}, {31'd0, cur[i].st});
          chk($sformatf("u%0d_dump_stop", i), {31'd0, sp[i]}, {31'd0, cur[i].sp});
        end else begin
          chk($sformatf("u%0d_idle_strobes", i), {30'd0, st[i], sp[i]}, 32'd0);
        end
        if (fp[i]) begin
          if (q[i].size() == 0) begin
            chk($sformatf("u%0d_unexpected_pulse", i), 32'd1, 32'd0);
          end else begin
            cur[i] = q[i].pop_front();
            chk($sformatf("u%0d_pulse_cycle", i), cyc, cur[i].cyc);
            pend[i] = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; vs = 1'b0; downloading = 1'b0;
    for (int i = 0; i < 4; i++) pend[i] = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    mon_on = 1'b1;
    chk("rst_frame_cnt", fc[0], 32'd0);
    chk("rst_dump_frames", df[0], 32'd0);
    chk("rst_outputs", {28'd0, fp[0], en[0], st[0], sp[0]}, 32'd0);
    rst_n = 1'b1;
    post_reset();

    repeat (4) frame();
    chk("u0_en_in_window", {31'd0, en[0]}, 32'd1);
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_dump_en", {31'd0, en[0]}, 32'd0);
    chk("midrst_frame_cnt", fc[0], 32'd0);
    chk("midrst_dump_stop", {31'd0, sp[0]}, 32'd0);
    post_reset();

    repeat (10) frame();
    chk("u0_fc_after_10", fc[0], 32'd10);
    chk("u0_en_after_window", {31'd0, en[0]}, 32'd0);
    chk("u1_en_unlimited", {31'd0, en[1]}, 32'd1);
    chk("u1_df_after_10", df[1], 32'd9);

    @(negedge clk);
    force u0.frame_cnt = 32'hFFFF_FFFE;
    exp_fc[0] = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    release u0.frame_cnt;
    repeat (3) frame();
    chk("u0_fc_wrapped", fc[0], 32'd1);

`ifdef JTFRAME_DUMP_LOADROM_EN
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    post_reset();
    repeat (4) frame();
    chk("dl_u0_en_before", {31'd0, en[0]}, 32'd1);
    downloading = 1'b1;
    in_dl = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n[i] = 0;
      exp_fc[i] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    chk("dl_u0_en_dropped", {31'd0, en[0]}, 32'd0);
    chk("dl_u0_fc_cleared", fc[0], 32'd0);
    chk("dl_u1_df_cleared", df[1], 32'd0);
    frame();
    downloading = 1'b0;
    in_dl = 1'b0;
    repeat (3) @(negedge clk);
    repeat (2) frame();
`endif

    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d_missing_pulses", i), q[i].size(), 32'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
